// File: rtl/pingpong_pkg.sv
// Shared types and default constants for the pingpong design.
// Holds the slow_clock_monitor state encoding and its parameter defaults.
package pingpong_pkg;

  typedef enum logic [1:0] {
    MON_IDLE   = 2'd0,
    MON_ARMED  = 2'd1,
    MON_LOCKED = 2'd2
  } mon_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT     = 1000;

endpackage

// File: rtl/sync_ff.sv
// Parameterized-depth flop synchronizer with synchronous active-high reset.
// Brings an asynchronous level into the clk domain; all stages clear to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking so every stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/slow_clock_monitor.sv
// Synchronizes a slow clock-like level, emits rise/fall ticks, measures the
// rise-to-rise period and flags loss. Optional: SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN.
module slow_clock_monitor
  import pingpong_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             slowIn,
  output logic             tickRise,
  output logic             tickFall,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  output logic             clkLost
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic sync;
  logic level_ok;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clkIn),
    .reset (reset),
    .d     (slowIn),
    .q     (sync)
  );

`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
  // One extra sample: a level is only trusted once seen on two consecutive cycles.
  localparam int FILL = SYNC_STAGES + 1;
  logic sync_d;

  always_ff @(posedge clkIn) begin
    if (reset) sync_d <= 1'b0;
    else       sync_d <= sync;
  end

  assign level_ok = (sync == sync_d);
`else
  localparam int FILL = SYNC_STAGES;
  assign level_ok = 1'b1;
`endif

  localparam int FILL_W = $clog2(FILL + 1);

  // Priming waits until the synchronizer carries a post-reset sample, so a
  // level already high at reset release is adopted silently.
  logic [FILL_W-1:0] fill_cnt;
  logic              primed;
  logic              prev;

  always_ff @(posedge clkIn) begin
    if (reset) begin
      fill_cnt <= '0;
      primed   <= 1'b0;
      prev     <= 1'b0;
    end else if (!primed) begin
      if (fill_cnt == FILL_W'(FILL)) begin
        if (level_ok) begin
          primed <= 1'b1;
          prev   <= sync;
        end
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end else if (level_ok) begin
      prev <= sync;
    end
  end

  logic rise_det, fall_det, edge_det;
  assign rise_det = primed & level_ok &  sync & ~prev;
  assign fall_det = primed & level_ok & ~sync &  prev;
  assign edge_det = rise_det | fall_det;

  logic [CNT_W-1:0] period_cnt, period_next;
  logic [CNT_W-1:0] to_cnt, to_next;
  logic             timeout_hit;

  assign period_next = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + 1'b1;
  assign to_next     = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 1'b1;
  assign timeout_hit = (to_cnt == TIMEOUT_VAL);

  mon_state_t state_q, state_d;

  always_ff @(posedge clkIn) begin
    if (reset) state_q <= MON_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    if (rise_det) begin
      unique case (state_q)
        MON_IDLE:   state_d = MON_ARMED;
        MON_ARMED:  state_d = MON_LOCKED;
        MON_LOCKED: state_d = MON_LOCKED;
        default:    state_d = MON_IDLE;
      endcase
    end else if (!fall_det && timeout_hit) begin
      state_d = MON_IDLE;
    end
  end

  always_ff @(posedge clkIn) begin
    if (reset) begin
      tickRise   <= 1'b0;
      tickFall   <= 1'b0;
      period     <= '0;
      period_cnt <= '0;
      to_cnt     <= '0;
      clkLost    <= 1'b0;
    end else begin
      tickRise   <= rise_det;
      tickFall   <= fall_det;
      period_cnt <= tickRise ? CNT_W'(1) : period_next;
      to_cnt     <= edge_det ? '0 : to_next;
      // period_next is the distance to the previous tick as seen by this tick.
      if (rise_det && state_q != MON_IDLE) period <= period_next;
      if (rise_det)                        clkLost <= 1'b0;
      else if (!fall_det && timeout_hit)   clkLost <= 1'b1;
    end
  end

  assign periodValid = (state_q == MON_LOCKED);

endmodule

// File: tb/tb_slow_clock_monitor.sv
// Randomized scoreboard bench for slow_clock_monitor: an edge/latency/timeout
// reference model predicts tick, period and loss events; a monitor compares them.
module tb_slow_clock_monitor;
  import pingpong_pkg::*;

  localparam int S    = 2;
  localparam int W    = 16;
  localparam int TO   = 1000;
  localparam int MAXC = 30000;
`ifdef SLOW_CLOCK_MONITOR_GLITCH_FILTER_EN
  localparam int D = S + 1;
  localparam bit FILT = 1'b1;
`else
  localparam int D = S;
  localparam bit FILT = 1'b0;
`endif

  logic         clkIn  = 1'b0;
  logic         reset  = 1'b1;
  logic         slowIn = 1'b0;
  logic         tickRise, tickFall, periodValid, clkLost;
  logic [W-1:0] period;

  always #5 clkIn = ~clkIn;

  slow_clock_monitor #(.SYNC_STAGES(S), .CNT_W(W), .TIMEOUT(TO)) dut (
    .clkIn       (clkIn),
    .reset       (reset),
    .slowIn      (slowIn),
    .tickRise    (tickRise),
    .tickFall    (tickFall),
    .period      (period),
    .periodValid (periodValid),
    .clkLost     (clkLost)
  );

  typedef struct {
    int           cyc;
    logic         rise;
    logic         fall;
    logic         lost;
    logic [W-1:0] per;
    logic         pvalid;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   end_req = 1'b0;

  // Reference model state: sample history plus event-level bookkeeping.
  logic         hist [0:MAXC];
  bit           seen_reset = 1'b0;
  bit           rst_edge   = 1'b0;
  int           last_rst   = 0;
  int           last_evt   = 0;
  int           last_rise  = 0;
  int           rises      = 0;
  bit           m_lost     = 1'b0;
  logic         m_level    = 1'b0;
  logic [W-1:0] m_period   = '0;

  function automatic logic [W-1:0] sat(input int d);
    return (d > (2**W) - 1) ? '1 : W'(d);
  endfunction

  function automatic exp_t mk(input logic r, input logic f, input logic l,
                              input logic [W-1:0] p, input logic v);
    exp_t e;
    e.cyc = cyc; e.rise = r; e.fall = f; e.lost = l; e.per = p; e.pvalid = v;
    return e;
  endfunction

  always @(posedge clkIn) begin
    int   n;
    logic e_rise, e_fall, ok;
    cyc = cyc + 1;
    if (cyc <= MAXC) hist[cyc] = slowIn;
    rst_edge = reset;
    e_rise = 1'b0;
    e_fall = 1'b0;
    if (reset) begin
      seen_reset = 1'b1;
      last_rst   = cyc;
      last_evt   = cyc;
      rises      = 0;
      m_lost     = 1'b0;
      m_period   = '0;
    end else if (seen_reset && cyc <= MAXC) begin
      n = cyc - D;
      if (n == last_rst + 1) begin
        m_level = hist[n];
      end else if (n >= last_rst + 2) begin
        ok = FILT ? (hist[n] == hist[n+1]) : 1'b1;
        if (ok && hist[n] != m_level) begin
          m_level = hist[n];
          e_rise  = m_level;
          e_fall  = ~m_level;
        end
      end
      if (e_rise) begin
        if (rises >= 1) m_period = sat(cyc - last_rise);
        rises     = (rises >= 2) ? 2 : rises + 1;
        last_rise = cyc;
        last_evt  = cyc;
        m_lost    = 1'b0;
        sbq.push_back(mk(1'b1, 1'b0, 1'b0, m_period, rises >= 2));
      end else if (e_fall) begin
        last_evt = cyc;
        sbq.push_back(mk(1'b0, 1'b1, m_lost, m_period, rises >= 2));
      end else if (!m_lost && cyc == last_evt + TO + 1) begin
        m_lost = 1'b1;
        rises  = 0;
        sbq.push_back(mk(1'b0, 1'b0, 1'b1, m_period, 1'b0));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic lost_prev = 1'b0;

  always @(negedge clkIn) begin
    exp_t e;
    if (rst_edge) begin
      check("rst_tickRise", 32'(tickRise), 0);
      check("rst_tickFall", 32'(tickFall), 0);
      check("rst_period", 32'(period), 0);
      check("rst_periodValid", 32'(periodValid), 0);
      check("rst_clkLost", 32'(clkLost), 0);
    end
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      check("missed_event_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      e = sbq.pop_front();
      check("tickRise", 32'(tickRise), 32'(e.rise));
      check("tickFall", 32'(tickFall), 32'(e.fall));
      check("clkLost", 32'(clkLost), 32'(e.lost));
      check("period", 32'(period), 32'(e.per));
      check("periodValid", 32'(periodValid), 32'(e.pvalid));
    end else if (tickRise || tickFall || (clkLost && !lost_prev)) begin
      check("unexpected_event", {29'd0, tickRise, tickFall, clkLost}, 0);
    end
    lost_prev = clkLost;
    if (end_req) begin
      check("queue_empty", 32'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clkIn);
      #1 slowIn = v;
    end
  endtask

  task automatic rst(input int n);
    @(posedge clkIn);
    #1 reset = 1'b1;
    repeat (n) @(posedge clkIn);
    #1 reset = 1'b0;
  endtask

  task automatic square(input int half, input int count);
    repeat (count) begin
      drive(1'b1, half);
      drive(1'b0, half);
    end
  endtask

  initial begin
    repeat (3) @(posedge clkIn);
    #1 reset = 1'b0;
    drive(1'b0, 8);
    square(1, 20);            // divide-by-2 of clkIn
    square(5, 6);             // period 10
    drive(1'b0, 1100);        // slow clock stops -> loss
    square(5, 3);             // recovery: arm, then lock
    drive(1'b1, 1001);        // tick lands on the timeout cycle: edge wins
    drive(1'b0, 1000);
    drive(1'b1, 1002);        // one cycle too long: loss then recovery
    drive(1'b0, 6);
    drive(1'b1, 8);           // held high through reset release
    rst(2);
    drive(1'b1, 10);
    drive(1'b0, 10);
    square(4, 4);             // lock, then reset mid-period
    drive(1'b1, 2);
    rst(1);
    drive(1'b1, 6);
    square(4, 3);
    drive(1'b0, 10);          // 1-cycle glitch, then 2-cycle pulse
    drive(1'b1, 1);
    drive(1'b0, 10);
    drive(1'b1, 2);
    drive(1'b0, 10);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) drive(slowIn, $urandom_range(995, 1005));
      else                            drive(~slowIn, $urandom_range(1, 12));
    end
    drive(slowIn, 30);
    end_req = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
